key_event_arbiter: RTL and testbench
====================================

// Module: key_event_arbiter
// PURPOSE
//  Collects press/release results from NUM_KEYS key_debounce instances (key_flag/key_value pairs)
//  and serialises them, round-robin, into one event stream with valid/ready handshake. Sits between
//  the debounce bank and the stepper/parking command controller, which consumes one event at a time.
// PARAMETERS
//  NUM_KEYS     4           number of debounced keys serviced (2..16)
//  KEY_ACTIVE   1'b0        key_value level meaning "pressed" (keys are active-low)
//  HOLD_CYCLES  50_000_000  cycles a key must stay pressed before a HOLD event (1 s @ 50 MHz)
// PORTS
//  sys_clk       in   1             system clock, 50 MHz
//  sys_rst_n     in   1             reset, synchronous, active-low
//  key_flag      in   NUM_KEYS      1-cycle "debounced value updated" pulse per key
//  key_value     in   NUM_KEYS      debounced key level per key
//  evt_valid     out  1             event presented; held until accepted
//  evt_ready     in   1             consumer accepts event when evt_valid & evt_ready
//  evt_key       out  KW            key index, KW = $clog2(NUM_KEYS)
//  evt_type      out  2             00 PRESS, 01 RELEASE, 10 HOLD, 11 unused
//  evt_overflow  out  1             1-cycle pulse: a new event was dropped (slot full)
// BEHAVIOUR
//  - Reset (sys_rst_n==0 at sys_clk edge): evt_valid=0, evt_key=0, evt_type=0, evt_overflow=0,
//    all slots empty, rr pointer=0, FSM=ARB, hold counters cleared. Reset mid-handshake drops event.
//  - Event capture: key_flag[i] & key_value[i]==KEY_ACTIVE -> PRESS; key_flag[i] & !=KEY_ACTIVE -> RELEASE.
//  - One slot per key {full, type}. Slot written cycle after key_flag. Slot already full (and not
//    being consumed same cycle) -> new event dropped, evt_overflow pulses 1 cycle after key_flag.
//  - Slot consumed in same cycle as new event for same key -> new event written (no overflow).
//  - FSM ARB: scan slots starting at rr pointer, wrapping mod NUM_KEYS; first full slot wins ->
//    load evt_key/evt_type, evt_valid=1, go SEND. No full slot -> stay ARB.
//  - FSM SEND: hold evt_valid/evt_key/evt_type stable while evt_ready=0. On evt_valid&evt_ready:
//    clear that slot, rr pointer = granted index+1 (wrap to 0 after NUM_KEYS-1), evt_valid=0, go ARB.
//  - Latency: key_flag at cycle t -> slot full at t+1 -> evt_valid at t+2 (idle arbiter, ready high).
//  - Throughput: one event per 2 cycles max (ARB/SEND alternate); never back-to-back valid.
//  - Fairness: a continuously full key cannot be granted twice while another slot is full.
//  - key_flag with unchanged key_value still generates an event (no filtering of repeats).
// CONFIGURATION
//  LONG_PRESS_EN defined: per-key counter starts at PRESS capture, clears on RELEASE; on reaching
//    HOLD_CYCLES-1 a HOLD event is posted to that key's slot once per press (same overflow rule;
//    a PRESS/RELEASE arriving in the same cycle as HOLD for one key wins, HOLD counts as dropped).
//    Counter saturates; no repeat HOLD until released and pressed again.
//  LONG_PRESS_EN undefined: no counters instantiated, evt_type never 10, HOLD_CYCLES unused.
// STRUCTURE
//  key_evt_pkg: EVT_PRESS/EVT_RELEASE/EVT_HOLD 2-bit constants, FSM state encoding (ARB, SEND).
//  Sub-module key_hold_timer (one per key, generated only under LONG_PRESS_EN):
//    in press/release strobes, out 1-cycle hold pulse; 26-bit counter sized from HOLD_CYCLES.
//  Top: slot array, round-robin scan (combinational priority from rr pointer), 2-state FSM.
// TESTING (bench with NUM_KEYS=4, HOLD_CYCLES=20 for sim)
//  1. key_flag[2] pulse, key_value[2]=0, evt_ready=1 -> evt_valid 2 cycles later, evt_key=2, type=00.
//  2. flags on keys 0,1,3 same cycle, ready=1 -> events in order 0,1,3, each valid 1 cycle, gaps 1 cycle.
//  3. evt_ready=0 for 10 cycles with key 1 pending -> evt_valid/key/type stable all 10 cycles; accepted on 11th.
//  4. key 0 pending, ready=0, second key_flag[0] -> evt_overflow 1-cycle pulse; only first event delivered.
//  5. Reset asserted while SEND -> next cycle evt_valid=0, slots empty; no event after release of reset.
//  6. LONG_PRESS_EN: press key 3, hold 25 cycles -> PRESS then exactly one HOLD (type 10); release -> RELEASE;
//     without macro, same stimulus -> PRESS, RELEASE only.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared constants for the key event arbiter: event type codes and the
// two-state arbitration FSM encoding.
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_HOLD    = 2'b10;

    typedef enum logic {
        ARB  = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/key_hold_timer.sv
// Per-key long-press timer, present only when LONG_PRESS_EN is defined.
// Starts counting on a press strobe, stops on a release strobe, and emits a
// single one-cycle hold pulse once the key has been held HOLD_CYCLES cycles.
// The counter then stays idle until the next press.
`ifdef LONG_PRESS_EN
module key_hold_timer
    import key_evt_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic press_i,
    input  logic release_i,
    output logic hold_o
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    assign hold_o = active_q && (cnt_q == HOLD_LAST);

    // Next-state: restart on press, disarm on release or once the hold fires
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (press_i) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (release_i) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            if (cnt_q == HOLD_LAST) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and armed flag registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule
`endif

// File: rtl/key_event_arbiter.sv
// Serialises press/release (and optional hold) events from a bank of
// debounced keys into one valid/ready event stream. Each key owns a
// one-deep slot; a round-robin scan picks the next full slot and a two-state
// FSM (ARB/SEND) presents it until the consumer accepts it.
// Optional feature: define LONG_PRESS_EN to add per-key hold timers that post
// a HOLD event once per press after HOLD_CYCLES cycles.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int   NUM_KEYS    = 4,
    parameter logic KEY_ACTIVE  = 1'b0,
    parameter int   HOLD_CYCLES = 50_000_000,
    localparam int  KW          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_value,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KW-1:0]       evt_key,
    output logic [1:0]          evt_type,
    output logic                evt_overflow
);

    logic [NUM_KEYS-1:0]       slot_full_q, slot_full_d;
    logic [NUM_KEYS-1:0][1:0]  slot_type_q, slot_type_d;
    logic                      overflow_q, overflow_d;

    arb_state_t                state_q, state_d;
    logic                      evt_valid_q, evt_valid_d;
    logic [KW-1:0]             evt_key_q, evt_key_d;
    logic [1:0]                evt_type_q, evt_type_d;
    logic [KW-1:0]             rr_q, rr_d;

    logic                      consume;
    logic                      grant_found;
    logic [KW-1:0]             grant_idx;
    logic [KW-1:0]             scan_idx;
    int                        scan_pos;
    logic                      new_evt;
    logic [1:0]                new_type;

    assign consume = (state_q == SEND) && evt_valid_q && evt_ready;

`ifdef LONG_PRESS_EN
    logic [NUM_KEYS-1:0] hold_pulse;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_hold
        key_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_hold_timer (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .press_i   (key_flag[g] && (key_value[g] == KEY_ACTIVE)),
            .release_i (key_flag[g] && (key_value[g] != KEY_ACTIVE)),
            .hold_o    (hold_pulse[g])
        );
    end
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^HOLD_CYCLES;
`endif

    // Slot update: capture new events, free the slot being accepted, flag drops
    always_comb begin
        slot_full_d = slot_full_q;
        slot_type_d = slot_type_q;
        overflow_d  = 1'b0;
        new_evt     = 1'b0;
        new_type    = EVT_PRESS;
        if (consume) begin
            slot_full_d[evt_key_q] = 1'b0;
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            new_evt  = 1'b0;
            new_type = EVT_PRESS;
            if (key_flag[i]) begin
                new_evt  = 1'b1;
                new_type = (key_value[i] == KEY_ACTIVE) ? EVT_PRESS : EVT_RELEASE;
            end
`ifdef LONG_PRESS_EN
            else if (hold_pulse[i]) begin
                new_evt  = 1'b1;
                new_type = EVT_HOLD;
            end
            // A press/release colliding with the hold wins; the hold is lost
            if (key_flag[i] && hold_pulse[i]) begin
                overflow_d = 1'b1;
            end
`endif
            if (new_evt) begin
                if (slot_full_q[i] && !(consume && (evt_key_q == KW'(i)))) begin
                    overflow_d = 1'b1;
                end else begin
                    slot_full_d[i] = 1'b1;
                    slot_type_d[i] = new_type;
                end
            end
        end
    end

    // Round-robin scan: first full slot at or after the rr pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        scan_pos    = 0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            scan_pos = (int'(rr_q) + k) % NUM_KEYS;
            scan_idx = KW'(scan_pos);
            if (!grant_found && slot_full_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // FSM next-state: ARB loads a winner, SEND waits for the handshake
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_type_d  = evt_type_q;
        rr_d        = rr_q;
        case (state_q)
            ARB: begin
                if (grant_found) begin
                    evt_key_d   = grant_idx;
                    evt_type_d  = slot_type_q[grant_idx];
                    evt_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (consume) begin
                    evt_valid_d = 1'b0;
                    rr_d        = (evt_key_q == KW'(NUM_KEYS - 1)) ? '0 : evt_key_q + 1'b1;
                    state_d     = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Slot array and overflow pulse registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            slot_full_q <= '0;
            slot_type_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
            slot_type_q <= slot_type_d;
            overflow_q  <= overflow_d;
        end
    end

    // FSM state, registered event outputs and rr pointer
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ARB;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= EVT_PRESS;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_type_q  <= evt_type_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_key      = evt_key_q;
    assign evt_type     = evt_type_q;
    assign evt_overflow = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Testbench for key_event_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized phase against an event-level reference model.
`timescale 1ns/1ps
module tb_key_event_arbiter;

    localparam int NK   = 4;
    localparam int HOLD = 20;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_flag;
    logic [3:0]  key_value;
    logic        evt_ready;
    logic        evt_valid;
    logic [1:0]  evt_key;
    logic [1:0]  evt_type;
    logic        evt_overflow;

    int checks = 0;
    int errors = 0;

    key_event_arbiter #(
        .NUM_KEYS    (NK),
        .KEY_ACTIVE  (1'b0),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .key_flag     (key_flag),
        .key_value    (key_value),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_type     (evt_type),
        .evt_overflow (evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        key_flag  = 4'b0000;
        key_value = 4'b1111;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [3:0] flag;
        logic [3:0] value;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_key;
        logic [1:0] exp_type;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[18];

    // ---------------- reference model ----------------
    // Event-level view: each key has at most one pending event (-1 = none),
    // the arbiter either presents one key's event or is idle.
    int m_pend[NK];
    int m_rr;
    int m_cur;
    int m_type;
    int m_edge;
    int m_hold_start[NK];
    bit m_hold_armed[NK];
    bit m_ovf;

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_pend[i]       = -1;
            m_hold_armed[i] = 1'b0;
            m_hold_start[i] = 0;
        end
        m_rr   = 0;
        m_cur  = -1;
        m_type = 0;
        m_edge = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] f, input logic [3:0] v, input logic r);
        int  np[NK];
        bit  acc;
        bit  hold_try;
        int  t;
        acc   = (m_cur >= 0) && r;
        m_ovf = 1'b0;
        for (int i = 0; i < NK; i++) np[i] = m_pend[i];
        if (acc) np[m_cur] = -1;
        for (int i = 0; i < NK; i++) begin
            hold_try = 1'b0;
`ifdef LONG_PRESS_EN
            hold_try = m_hold_armed[i] && ((m_edge - m_hold_start[i]) == HOLD);
`endif
            if (f[i] || hold_try) begin
                t = f[i] ? ((v[i] == 1'b0) ? 0 : 1) : 2;
                if (m_pend[i] >= 0 && !(acc && m_cur == i)) m_ovf = 1'b1;
                else np[i] = t;
                if (f[i] && hold_try) m_ovf = 1'b1;
            end
            if (f[i]) begin
                if (v[i] == 1'b0) begin
                    m_hold_armed[i] = 1'b1;
                    m_hold_start[i] = m_edge;
                end else begin
                    m_hold_armed[i] = 1'b0;
                end
            end else if (hold_try) begin
                m_hold_armed[i] = 1'b0;
            end
        end
        if (m_cur < 0) begin
            for (int k = 0; k < NK; k++) begin
                int idx;
                idx = (m_rr + k) % NK;
                if (m_cur < 0 && m_pend[idx] >= 0) begin
                    m_cur  = idx;
                    m_type = m_pend[idx];
                end
            end
        end else if (acc) begin
            m_rr  = (m_cur + 1) % NK;
            m_cur = -1;
        end
        for (int i = 0; i < NK; i++) m_pend[i] = np[i];
        m_edge++;
    endtask

    int collected[$];
    int expected[$];

    initial begin
        rst_n     = 1'b0;
        key_flag  = 4'b0000;
        key_value = 4'b1111;
        evt_ready = 1'b1;

        // rst, flag, value, ready, exp_valid, exp_key, exp_type, exp_ovf
        vecs[0]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 4'b1011, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 4'b1011, 1'b1, 1'b1, 2'd2, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 4'b1011, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 4'b1011, 4'b1100, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b1, 2'd0, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[8]  = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b1, 2'd1, 2'b00, 1'b0};
        vecs[9]  = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b1, 2'd3, 2'b01, 1'b0};
        vecs[11] = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[12] = '{1'b1, 4'b0000, 4'b1100, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[13] = '{1'b1, 4'b0100, 4'b1011, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[14] = '{1'b1, 4'b0000, 4'b1011, 1'b1, 1'b1, 2'd2, 2'b00, 1'b0};
        vecs[15] = '{1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};
        vecs[16] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd2, 2'b01, 1'b0};
        vecs[17] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0};

        for (int n = 0; n < 18; n++) begin
            rst_n     = vecs[n].rst_n;
            key_flag  = vecs[n].flag;
            key_value = vecs[n].value;
            evt_ready = vecs[n].ready;
            tick();
            check($sformatf("vec%0d valid", n), 32'(evt_valid), 32'(vecs[n].exp_valid));
            check($sformatf("vec%0d overflow", n), 32'(evt_overflow), 32'(vecs[n].exp_ovf));
            if (vecs[n].exp_valid) begin
                check($sformatf("vec%0d key", n), 32'(evt_key), 32'(vecs[n].exp_key));
                check($sformatf("vec%0d type", n), 32'(evt_type), 32'(vecs[n].exp_type));
            end
        end

        // Back-pressure: key 1 held for 10 cycles, accepted on the 11th
        do_reset();
        evt_ready = 1'b0;
        key_flag  = 4'b0010;
        key_value = 4'b1101;
        tick();
        key_flag = 4'b0000;
        tick();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall%0d valid", c), 32'(evt_valid), 32'd1);
            check($sformatf("stall%0d key", c), 32'(evt_key), 32'd1);
            check($sformatf("stall%0d type", c), 32'(evt_type), 32'd0);
            if (c < 9) tick();
        end
        evt_ready = 1'b1;
        tick();
        check("stall accept valid", 32'(evt_valid), 32'd0);

        // Overflow: second event on key 0 while its slot is still pending
        do_reset();
        evt_ready = 1'b0;
        key_flag  = 4'b0001;
        key_value = 4'b1110;
        tick();
        key_flag  = 4'b0001;
        key_value = 4'b1111;
        tick();
        check("ovf pulse", 32'(evt_overflow), 32'd1);
        check("ovf valid", 32'(evt_valid), 32'd1);
        check("ovf key", 32'(evt_key), 32'd0);
        check("ovf type", 32'(evt_type), 32'd0);
        key_flag = 4'b0000;
        tick();
        check("ovf pulse end", 32'(evt_overflow), 32'd0);
        evt_ready = 1'b1;
        tick();
        check("ovf accepted", 32'(evt_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("ovf no second event %0d", c), 32'(evt_valid), 32'd0);
        end

        // Reset during SEND drops the presented event and the other pending slot
        do_reset();
        evt_ready = 1'b0;
        key_flag  = 4'b1100;
        key_value = 4'b0011;
        tick();
        key_flag = 4'b0000;
        tick();
        check("rst-send valid before", 32'(evt_valid), 32'd1);
        check("rst-send key before", 32'(evt_key), 32'd2);
        rst_n = 1'b0;
        tick();
        check("rst-send valid", 32'(evt_valid), 32'd0);
        check("rst-send key", 32'(evt_key), 32'd0);
        check("rst-send type", 32'(evt_type), 32'd0);
        check("rst-send overflow", 32'(evt_overflow), 32'd0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rst-send idle %0d", c), 32'(evt_valid), 32'd0);
        end

        // Long press on key 3: PRESS, (HOLD when enabled), RELEASE
        do_reset();
        evt_ready = 1'b1;
        key_flag  = 4'b1000;
        key_value = 4'b0111;
        tick();
        if (evt_valid) collected.push_back(int'(evt_type));
        key_flag = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (evt_valid) collected.push_back(int'(evt_type));
        end
        key_flag  = 4'b1000;
        key_value = 4'b1111;
        tick();
        if (evt_valid) collected.push_back(int'(evt_type));
        key_flag = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (evt_valid) collected.push_back(int'(evt_type));
        end
        expected.push_back(0);
`ifdef LONG_PRESS_EN
        expected.push_back(2);
`endif
        expected.push_back(1);
        check("hold event count", 32'(collected.size()), 32'(expected.size()));
        for (int e = 0; e < expected.size(); e++) begin
            if (e < collected.size())
                check($sformatf("hold event %0d type", e), 32'(collected[e]), 32'(expected[e]));
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2200; c++) begin
            int rate;
            logic [3:0] f;
            rate = (c < 900) ? 6 : 40;
            for (int i = 0; i < NK; i++) f[i] = ($urandom_range(0, rate - 1) == 0);
            key_flag  = f;
            key_value = 4'($urandom_range(0, 15));
            evt_ready = ($urandom_range(0, 3) != 0);
            model_step(key_flag, key_value, evt_ready);
            tick();
            check($sformatf("rnd%0d valid", c), 32'(evt_valid), 32'(m_cur >= 0));
            check($sformatf("rnd%0d overflow", c), 32'(evt_overflow), 32'(m_ovf));
            if (m_cur >= 0) begin
                check($sformatf("rnd%0d key", c), 32'(evt_key), 32'(m_cur));
                check($sformatf("rnd%0d type", c), 32'(evt_type), 32'(m_type));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
